// File: rtl/mypkg.sv
// rtl/mypkg.sv - shared command, coherence and FSM types for cache_ctrl
package mypkg;

  typedef enum logic [2:0] {
    CMD_READ       = 3'd0,
    CMD_WRITE      = 3'd1,
    CMD_I_FETCH    = 3'd2,
    CMD_L2_INVAL   = 3'd3,
    CMD_L2_DATA_RQ = 3'd4,
    CMD_CLR        = 3'd5,
    CMD_PRINT      = 3'd6,
    CMD_ILLEGAL    = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  localparam int STAT_W = 32;

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set age update and victim choice for one set
module cache_lru #(
  parameter int WAYS = 2
) (
  input  logic [WAYS*$clog2(WAYS)-1:0] ages,
  input  logic [WAYS-1:0]              valid,
  input  logic [$clog2(WAYS)-1:0]      touch_way,
  output logic [WAYS*$clog2(WAYS)-1:0] ages_next,
  output logic [$clog2(WAYS)-1:0]      victim
);

  localparam int AW = $clog2(WAYS);

  logic [AW-1:0] touch_age;
  logic          found;

  // Move-to-front: younger ways than the touched one age by one.
  always_comb begin
    ages_next = ages;
    touch_age = ages[touch_way*AW +: AW];
    for (int w = 0; w < WAYS; w++) begin
      if (w == int'(touch_way)) begin
        ages_next[w*AW +: AW] = '0;
      end else if (ages[w*AW +: AW] < touch_age) begin
        ages_next[w*AW +: AW] = ages[w*AW +: AW] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim = AW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w*AW +: AW] == AW'(WAYS-1)) victim = AW'(w);
      end
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - MESI tag/state controller with LRU replacement and statistics
module cache_ctrl
  import mypkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_cmd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic                  rsp_wb,
  output logic [ADDR_WIDTH-1:0] rsp_wb_addr,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

  state_e state, state_next;
  cmd_e   cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  mesi_e            mesi_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  logic [WAY_W-1:0] age_q  [SETS][WAYS];

  logic                  hit_q, wb_q;
  logic [WAY_W-1:0]      way_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [IDX_W-1:0]      clr_idx;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_offset;

  assign idx           = addr_q[OFF_W +: IDX_W];
  assign tag           = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign unused_offset = ^addr_q[OFF_W-1:0];

  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAYS-1:0]       valid_vec;
  logic [WAYS*WAY_W-1:0] ages_flat, ages_next;
  logic [WAY_W-1:0]      victim;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    ages_flat = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = (mesi_q[idx][w] != MESI_I);
      ages_flat[w*WAY_W +: WAY_W] = age_q[idx][w];
      if (valid_vec[w] && tag_q[idx][w] == tag && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .ages      (ages_flat),
    .valid     (valid_vec),
    .touch_way (way_q),
    .ages_next (ages_next),
    .victim    (victim)
  );

  logic                  lk_wb;
  logic [WAY_W-1:0]      lk_way;
  logic [ADDR_WIDTH-1:0] lk_wb_addr;
  mesi_e                 sel_mesi;

  // Accesses write back a dirty victim; snoops hand back the dirty hit line.
  always_comb begin
    lk_way     = hit ? hit_way : victim;
    lk_wb      = 1'b0;
    lk_wb_addr = '0;
    sel_mesi   = mesi_q[idx][lk_way];
    case (cmd_q)
      CMD_READ, CMD_WRITE, CMD_I_FETCH: begin
        if (!hit && sel_mesi == MESI_M) begin
          lk_wb      = 1'b1;
          lk_wb_addr = {tag_q[idx][lk_way], idx, {OFF_W{1'b0}}};
        end
      end
      CMD_L2_INVAL, CMD_L2_DATA_RQ: begin
        if (hit && sel_mesi == MESI_M) begin
          lk_wb      = 1'b1;
          lk_wb_addr = {tag, idx, {OFF_W{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_hit     = 1'b0;
    rsp_wb      = 1'b0;
    rsp_wb_addr = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: state_next = (cmd_q == CMD_CLR) ? ST_CLEAR : ST_UPDATE;
      ST_UPDATE: begin
        rsp_valid   = 1'b1;
        rsp_hit     = hit_q;
        rsp_wb      = wb_q;
        rsp_wb_addr = wb_addr_q;
        state_next  = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_idx == IDX_W'(SETS-1)) begin
          rsp_valid  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= CMD_READ;
      addr_q    <= '0;
      hit_q     <= 1'b0;
      wb_q      <= 1'b0;
      way_q     <= '0;
      wb_addr_q <= '0;
      clr_idx   <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        cmd_q  <= cmd_e'(req_cmd);
        addr_q <= req_addr;
      end
      if (state == ST_LOOKUP) begin
        hit_q     <= hit && cmd_q != CMD_PRINT && cmd_q != CMD_CLR;
        wb_q      <= lk_wb;
        way_q     <= lk_way;
        wb_addr_q <= lk_wb_addr;
        clr_idx   <= '0;
      end
      if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mesi_q[s][w] <= MESI_I;
          tag_q[s][w]  <= '0;
          age_q[s][w]  <= WAY_W'(w);
        end
      end
    end else if (state == ST_CLEAR) begin
      for (int w = 0; w < WAYS; w++) begin
        mesi_q[clr_idx][w] <= MESI_I;
        age_q[clr_idx][w]  <= WAY_W'(w);
      end
    end else if (state == ST_UPDATE) begin
      case (cmd_q)
        CMD_READ, CMD_I_FETCH, CMD_WRITE: begin
          if (cmd_q == CMD_WRITE) begin
            mesi_q[idx][way_q] <= MESI_M;
            tag_q[idx][way_q]  <= tag;
          end else if (!hit_q) begin
            mesi_q[idx][way_q] <= MESI_E;
            tag_q[idx][way_q]  <= tag;
          end
          for (int w = 0; w < WAYS; w++) age_q[idx][w] <= ages_next[w*WAY_W +: WAY_W];
        end
        CMD_L2_INVAL: begin
          if (hit_q) mesi_q[idx][way_q] <= MESI_I;
        end
        CMD_L2_DATA_RQ: begin
          if (hit_q && (mesi_q[idx][way_q] == MESI_M || mesi_q[idx][way_q] == MESI_E))
            mesi_q[idx][way_q] <= MESI_S;
        end
        default: ;
      endcase
    end
  end

  logic is_access;
  assign is_access = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE) || (cmd_q == CMD_I_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == ST_CLEAR && clr_idx == IDX_W'(SETS-1)) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == ST_UPDATE && is_access) begin
      if (cmd_q == CMD_WRITE) stat_writes <= sat_inc(stat_writes);
      else                    stat_reads  <= sat_inc(stat_reads);
      if (hit_q) stat_hits   <= sat_inc(stat_hits);
      else       stat_misses <= sat_inc(stat_misses);
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - cache_ctrl against a recency-list MESI cache model
module tb_cache_ctrl;

  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_valid, rsp_hit, rsp_wb;
  logic [31:0] rsp_wb_addr;
  logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_WIDTH(32), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_wb(rsp_wb), .rsp_wb_addr(rsp_wb_addr), .stat_reads(stat_reads),
    .stat_writes(stat_writes), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model: state 0=I 1=S 2=E 3=M; m_rec lists ways most-recent first.
  int          m_state [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int          m_rec   [SETS][$];
  logic [31:0] m_reads, m_writes, m_hits, m_misses;
  logic        last_hit, last_wb;
  logic [31:0] last_wb_addr;

  function automatic logic [31:0] sinc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rec[s] = {};
      for (int w = 0; w < WAYS; w++) begin
        m_state[s][w] = 0;
        m_rec[s].push_back(w);
      end
    end
    m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic touch(input int s, input int w);
    for (int i = 0; i < m_rec[s].size(); i++) begin
      if (m_rec[s][i] == w) begin
        m_rec[s].delete(i);
        break;
      end
    end
    m_rec[s].push_front(w);
  endtask

  task automatic model_op(input int cmd, input logic [31:0] addr,
                          output bit hit, output bit wb, output logic [31:0] wa);
    int s, hw, v;
    int unsigned t;
    s = int'(addr[9:6]);
    t = addr >> 10;
    hit = 0; wb = 0; wa = 0; hw = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_state[s][w] != 0 && m_tag[s][w] == t) begin hit = 1; hw = w; end
    case (cmd)
      0, 1, 2: begin
        if (cmd == 1) m_writes = sinc(m_writes); else m_reads = sinc(m_reads);
        if (hit) begin
          m_hits = sinc(m_hits);
          v = hw;
          if (cmd == 1) m_state[s][v] = 3;
        end else begin
          m_misses = sinc(m_misses);
          v = -1;
          for (int w = WAYS-1; w >= 0; w--) if (m_state[s][w] == 0) v = w;
          if (v < 0) v = m_rec[s][WAYS-1];
          if (m_state[s][v] == 3) begin
            wb = 1;
            wa = (m_tag[s][v] << 10) | (s << 6);
          end
          m_tag[s][v]   = t;
          m_state[s][v] = (cmd == 1) ? 3 : 2;
        end
        touch(s, v);
      end
      3: if (hit) begin
        if (m_state[s][hw] == 3) begin wb = 1; wa = addr & ~32'd63; end
        m_state[s][hw] = 0;
      end
      4: if (hit) begin
        if (m_state[s][hw] == 3) begin wb = 1; wa = addr & ~32'd63; end
        if (m_state[s][hw] >= 2) m_state[s][hw] = 1;
      end
      5: begin model_clear(); hit = 0; end
      6: hit = 0;
      default: ;
    endcase
  endtask

  task automatic do_req(input logic [2:0] cmd, input logic [31:0] addr);
    bit e_hit, e_wb;
    logic [31:0] e_wa;
    int n, lat;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("req_ready", req_ready, 1);
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    model_op(int'(cmd), addr, e_hit, e_wb, e_wa);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    check_eq("latency", lat, (cmd == 3'd5) ? 17 : 2);
    check_eq("rsp_hit", rsp_hit, e_hit);
    check_eq("rsp_wb", rsp_wb, e_wb);
    check_eq("rsp_wb_addr", rsp_wb_addr, e_wa);
    last_hit = rsp_hit; last_wb = rsp_wb; last_wb_addr = rsp_wb_addr;
    @(negedge clk);
    check_eq("rsp_pulse", rsp_valid, 0);
    check_eq("stat_reads", stat_reads, m_reads);
    check_eq("stat_writes", stat_writes, m_writes);
    check_eq("stat_hits", stat_hits, m_hits);
    check_eq("stat_misses", stat_misses, m_misses);
  endtask

  int seen;

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", req_ready, 1);
    check_eq("reset_valid", rsp_valid, 0);
    check_eq("reset_wb", {rsp_hit, rsp_wb}, 0);
    check_eq("reset_wb_addr", rsp_wb_addr, 0);
    check_eq("reset_stats", stat_reads | stat_writes | stat_hits | stat_misses, 0);

    do_req(3'd0, 32'h0000_1040);
    check_eq("first_read_hit", last_hit, 0);
    do_req(3'd0, 32'h0000_1040);
    check_eq("second_read_hit", last_hit, 1);
    check_eq("reads_two", stat_reads, 2);
    check_eq("hits_one", stat_hits, 1);
    check_eq("misses_one", stat_misses, 1);

    do_req(3'd1, 32'h0000_0000);
    do_req(3'd0, 32'h0001_0000);
    do_req(3'd0, 32'h0002_0000);
    check_eq("evict_wb", last_wb, 1);
    check_eq("evict_wb_addr", last_wb_addr, 32'h0000_0000);

    do_req(3'd1, 32'h0000_2080);
    do_req(3'd4, 32'h0000_2080);
    check_eq("drq_hit", last_hit, 1);
    check_eq("drq_wb", last_wb, 1);
    do_req(3'd4, 32'h0000_2080);
    check_eq("drq_again_wb", last_wb, 0);

    for (int s = 0; s < SETS; s++) do_req(3'd0, 32'h0000_4000 | (s << 6));
    do_req(3'd5, 32'h0);
    check_eq("clr_stats", stat_reads | stat_writes | stat_hits | stat_misses, 0);
    do_req(3'd0, 32'h0000_4000 | (5 << 6));
    check_eq("after_clr_miss", last_hit, 0);

    for (int s = 0; s < 4; s++) do_req(3'd1, 32'h0000_8000 | (s << 6));
    req_valid = 1'b1; req_cmd = 3'd5; req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst = 1'b1;
    #2;
    if (rsp_valid) seen++;
    @(negedge clk);
    if (rsp_valid) seen++;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    if (rsp_valid) seen++;
    check_eq("abort_no_rsp", seen, 0);
    check_eq("abort_ready", req_ready, 1);
    for (int s = 0; s < 4; s++) begin
      do_req(3'd0, 32'h0000_8000 | (s << 6));
      check_eq("abort_line_inval", last_hit, 0);
    end

    for (int i = 0; i < 250; i++) begin
      int r;
      logic [2:0] c;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      c = (r < 30) ? 3'd0 : (r < 50) ? 3'd1 : (r < 60) ? 3'd2 : (r < 70) ? 3'd3 :
          (r < 80) ? 3'd4 : (r < 82) ? 3'd5 : (r < 91) ? 3'd6 : 3'd7;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      do_req(c, a);
    end

    do_req(3'd0, 32'h0000_3000);
    @(negedge clk);
    force dut.stat_hits = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.stat_hits;
    m_hits = 32'hFFFF_FFFF;
    do_req(3'd0, 32'h0000_3000);
    check_eq("sat_hit", last_hit, 1);
    check_eq("sat_hits", stat_hits, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
